psp_burst_ctrl: RTL and testbench

Burst sequencer for the pseudo-random sequence (PSP) generator. It owns a parameterised Fibonacci LFSR and emits exactly `len` sequence bits per request over a valid/ready stream. It supports seed reload, abort, and detection of the all-zero lock-up seed. It sits between the test/config logic, which issues start, length and seed, and any serial consumer of the PSP bit stream.

---
 rtl/psp_pkg.sv | 15 +
 rtl/psp_lfsr.sv | 38 +++
 rtl/psp_burst_ctrl.sv | 120 ++++++++++++
 tb/tb_psp_burst_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/psp_pkg.sv
// Shared types and default parameters for the PSP burst sequencer.
package psp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } psp_state_e;

    localparam int         PSP_WIDTH = 3;
    localparam logic [2:0] PSP_TAPS  = 3'b111;
    localparam logic [2:0] PSP_SEED  = 3'b100;
    localparam int         PSP_CNT_W = 8;

endpackage

// File: rtl/psp_lfsr.sv
// Fibonacci LFSR: shifts left with the masked-XOR feedback entering at bit 0.
module psp_lfsr
    import psp_pkg::*;
#(
    parameter int               WIDTH = PSP_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = PSP_TAPS,
    parameter logic [WIDTH-1:0] SEED  = PSP_SEED
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] state
);

    logic [WIDTH-1:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = load_val;
        end else if (step) begin
            state_d = {state_q[WIDTH-2:0], ^(state_q & TAPS)};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/psp_burst_ctrl.sv
// Emits exactly len LFSR bits per start over a valid/ready stream, with
// abort, seed reload and rejection of the all-zero lock-up seed.
module psp_burst_ctrl
    import psp_pkg::*;
#(
    parameter int               WIDTH = PSP_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = PSP_TAPS,
    parameter logic [WIDTH-1:0] SEED  = PSP_SEED,
    parameter int               CNT_W = PSP_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             abort,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic             busy,
    output logic             done,
    output logic             lockup
);

    psp_state_e       fsm_q, fsm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             lockup_q, lockup_d;
    logic             xfer;
    logic             seed_ld;
    logic             lfsr_load;
    logic [WIDTH-1:0] lfsr_state;

    assign xfer    = valid_q && out_ready;
    assign seed_ld = seed_load && (fsm_q == ST_IDLE);
    // A zero seed would freeze the LFSR, so it is refused rather than loaded.
    assign lfsr_load = seed_ld && (seed_in != '0);

    psp_lfsr #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .step     (xfer),
        .load     (lfsr_load),
        .load_val (seed_in),
        .state    (lfsr_state)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q    <= ST_IDLE;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            lockup_q <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            lockup_q <= lockup_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        cnt_d = cnt_q;
        case (fsm_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_d = len;
                    fsm_d = (len != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (xfer) begin
                    cnt_d = cnt_q - 1'b1;
                end
                // Abort wins over completion: a coinciding last transfer still
                // happens, but no done pulse follows.
                if (abort) begin
                    fsm_d = ST_IDLE;
                end else if (xfer && (cnt_q == CNT_W'(1))) begin
                    fsm_d = ST_DONE;
                end
            end
            ST_DONE: fsm_d = ST_IDLE;
            default: fsm_d = ST_IDLE;
        endcase
    end

    always_comb begin
        valid_d  = (fsm_d == ST_RUN);
        busy_d   = (fsm_d != ST_IDLE);
        done_d   = (fsm_d == ST_DONE);
        lockup_d = lockup_q;
        if (seed_ld) begin
            lockup_d = (seed_in == '0);
        end
    end

    // Only the MSB is streamed out; the lower bits just feed the shift.
    logic unused_state;
    assign unused_state = ^lfsr_state[WIDTH-2:0];

    assign out_valid = valid_q;
    assign out_bit   = lfsr_state[WIDTH-1];
    assign busy      = busy_q;
    assign done      = done_q;
    assign lockup    = lockup_q;

endmodule

// File: tb/tb_psp_burst_ctrl.sv
// Directed and randomized bursts against a bit-stream model of the PSP sequencer.
module tb_psp_burst_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] len;
    logic       abort;
    logic       seed_load;
    logic [2:0] seed_in;
    logic       out_valid;
    logic       out_ready;
    logic       out_bit;
    logic       busy;
    logic       done;
    logic       lockup;

    int checks = 0;
    int errors = 0;

    // Reference model: LFSR contents and sticky lock-up flag.
    logic [2:0] ms;
    logic       ml;

    psp_burst_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .abort     (abort),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bit   (out_bit),
        .busy      (busy),
        .done      (done),
        .lockup    (lockup)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] model_next(input logic [2:0] s);
        int ones;
        ones = $countones(s & 3'b111);
        return {s[1:0], 1'(ones % 2)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; start = 0; len = 0; abort = 0; seed_load = 0; seed_in = 0; out_ready = 0;
        tick;
        rst = 1'b0;
        ms = 3'b100;
        ml = 1'b0;
    endtask

    // mode: 0 = ready always, 1 = ready pattern 1,0,0,1, 2 = random ready.
    task automatic burst(input int n, input int mode, input int abort_at, input bit abort_rdy,
                         input bit sl, input logic [2:0] sv, input bit poke,
                         output logic [15:0] bits, output int got);
        int cyc;
        bit rdy, ab, ab_now;
        bits = '0; got = 0; cyc = 0; ab = 0;
        start = 1; len = 8'(n); seed_load = sl; seed_in = sv; abort = 1'($urandom_range(0, 1));
        tick;
        start = 0; seed_load = 0; abort = 0;
        if (sl) begin
            if (sv != 3'b000) begin ms = sv; ml = 1'b0; end
            else ml = 1'b1;
        end
        if (n == 0) begin
            chk("len0_valid", 32'(out_valid), 32'd0);
            chk("len0_done", 32'(done), 32'd1);
            chk("len0_busy", 32'(busy), 32'd1);
            abort = 1;
            tick;
            abort = 0;
            chk("len0_done_clr", 32'(done), 32'd0);
            chk("len0_idle", 32'(busy), 32'd0);
        end else begin
            while (got < n && !ab && cyc < 200) begin
                chk("run_valid", 32'(out_valid), 32'd1);
                chk("run_bit", 32'(out_bit), 32'(ms[2]));
                chk("run_busy", 32'(busy), 32'd1);
                chk("run_done", 32'(done), 32'd0);
                case (mode)
                    0: rdy = 1;
                    1: rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                    default: rdy = 1'($urandom_range(0, 1));
                endcase
                ab_now = (abort_at >= 0) && (got == abort_at);
                if (ab_now) rdy = abort_rdy;
                out_ready = rdy;
                abort = ab_now;
                if (poke && cyc == 1) begin start = 1; len = 8'd1; end
                tick;
                start = 0; abort = 0;
                if (rdy) begin
                    bits = {bits[14:0], ms[2]};
                    ms = model_next(ms);
                    got++;
                end
                if (ab_now) ab = 1;
                cyc++;
            end
            chk("timeout", 32'(cyc < 200), 32'd1);
            if (ab) begin
                chk("abort_valid", 32'(out_valid), 32'd0);
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_nodone", 32'(done), 32'd0);
            end else begin
                chk("end_done", 32'(done), 32'd1);
                chk("end_valid", 32'(out_valid), 32'd0);
                chk("end_busy", 32'(busy), 32'd1);
                tick;
                chk("end_done_clr", 32'(done), 32'd0);
                chk("end_idle", 32'(busy), 32'd0);
            end
        end
        chk("lockup", 32'(lockup), 32'(ml));
        chk("idle_bit", 32'(out_bit), 32'(ms[2]));
        out_ready = 0;
    endtask

    initial begin
        logic [15:0] bits;
        int          got;

        // Reset state, sampled while reset is still asserted.
        rst = 1'b1; start = 0; len = 0; abort = 0; seed_load = 0; seed_in = 0; out_ready = 0;
        #3;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_lockup", 32'(lockup), 32'd0);
        chk("rst_bit", 32'(out_bit), 32'd1);
        do_reset;

        // len 6, ready held high.
        burst(6, 0, -1, 0, 0, 3'b000, 0, bits, got);
        chk("s1_bits", 32'(bits[5:0]), 32'b100110);
        chk("s1_count", 32'(got), 32'd6);

        // len 4 under backpressure.
        do_reset;
        burst(4, 1, -1, 0, 0, 3'b000, 0, bits, got);
        chk("s2_bits", 32'(bits[3:0]), 32'b1001);

        // len 0.
        do_reset;
        burst(0, 0, -1, 0, 0, 3'b000, 0, bits, got);
        chk("s3_count", 32'(got), 32'd0);

        // Zero seed rejected, then valid seed 011.
        do_reset;
        seed_load = 1; seed_in = 3'b000;
        tick;
        seed_load = 0; ml = 1'b1;
        chk("zero_seed_lockup", 32'(lockup), 32'd1);
        chk("zero_seed_bit", 32'(out_bit), 32'd1);
        seed_load = 1; seed_in = 3'b011;
        tick;
        seed_load = 0; ms = 3'b011; ml = 1'b0;
        chk("seed_lockup_clr", 32'(lockup), 32'd0);
        chk("seed_bit", 32'(out_bit), 32'd0);
        burst(3, 0, -1, 0, 0, 3'b000, 0, bits, got);
        chk("s4_bits", 32'(bits[2:0]), 32'b011);

        // Abort after 3 transfers, then continue from state 110.
        do_reset;
        burst(8, 0, 3, 0, 0, 3'b000, 0, bits, got);
        chk("s5_abort_count", 32'(got), 32'd3);
        burst(2, 0, -1, 0, 0, 3'b000, 0, bits, got);
        chk("s5_bits", 32'(bits[1:0]), 32'b11);

        // start during RUN must not restart the burst.
        do_reset;
        burst(4, 0, -1, 0, 0, 3'b000, 1, bits, got);
        chk("s6_count", 32'(got), 32'd4);
        chk("s6_bits", 32'(bits[3:0]), 32'b1001);

        // Reset mid-burst; zero seed with start also sets lockup first.
        do_reset;
        start = 1; len = 8'd8; seed_load = 1; seed_in = 3'b000; out_ready = 1;
        tick;
        start = 0; seed_load = 0;
        tick;
        tick;
        start = 1; len = 8'd2;
        tick;
        start = 0;
        chk("mid_valid", 32'(out_valid), 32'd1);
        chk("mid_bit", 32'(out_bit), 32'd1);
        chk("mid_lockup", 32'(lockup), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_lockup", 32'(lockup), 32'd0);
        chk("arst_bit", 32'(out_bit), 32'd1);
        tick;
        rst = 1'b0; out_ready = 0;
        ms = 3'b100; ml = 1'b0;
        tick;
        chk("post_rst_idle", 32'(busy), 32'd0);
        chk("post_rst_done", 32'(done), 32'd0);

        // Randomized bursts with seeds, aborts and random backpressure.
        for (int i = 0; i < 40; i++) begin
            int         n, ab_at;
            bit         sl;
            logic [2:0] sv;
            n     = $urandom_range(0, 12);
            ab_at = ($urandom_range(0, 3) == 0 && n > 0) ? int'($urandom_range(0, n - 1)) : -1;
            sl    = 1'($urandom_range(0, 1));
            sv    = 3'($urandom_range(0, 7));
            burst(n, 2, ab_at, 1'($urandom_range(0, 1)), sl, sv, 0, bits, got);
            if (ab_at < 0) chk("rnd_count", 32'(got), 32'(n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
